// File: rtl/prim_ram_2p_pkg.sv
// Shared types for the single-clock dual-port RAM: read-during-write policy and
// zeroize sequencer states.
package prim_ram_2p_pkg;

    typedef enum logic {
        RdModeReadFirst  = 1'b0,
        RdModeWriteFirst = 1'b1
    } rd_mode_e;

    typedef enum logic {
        Clear = 1'b0,
        Idle  = 1'b1
    } clr_state_e;

endpackage

// File: rtl/prim_ram_2p_rd_stage.sv
// Per-port read path: out-of-range zeroing, write-first forwarding from the other
// port, optional output register and the matching rvalid pipeline.
module prim_ram_2p_rd_stage
    import prim_ram_2p_pkg::*;
#(
    parameter int unsigned Width     = 32,
    parameter int unsigned OutputReg = 0,
    parameter rd_mode_e    RdMode    = RdModeReadFirst
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic             in_range,
    input  logic [Width-1:0] mem_word,
    input  logic [Width-1:0] fwd_bits,
    input  logic [Width-1:0] fwd_data,
    output logic             rvalid,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] data_c;
    logic [Width-1:0] data_q;
    logic             valid_q;

    // Word as seen by this read; bits the other port writes this cycle override in write-first mode
    always_comb begin
        data_c = '0;
        if (in_range) begin
            if (RdMode == RdModeWriteFirst) begin
                data_c = (mem_word & ~fwd_bits) | (fwd_data & fwd_bits);
            end else begin
                data_c = mem_word;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= rd_en;
            if (rd_en) begin
                data_q <= data_c;
            end
        end
    end

    if (OutputReg != 0) begin : g_out_reg
        logic [Width-1:0] data_q2;
        logic             valid_q2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q2 <= 1'b0;
                data_q2  <= '0;
            end else begin
                valid_q2 <= valid_q;
                if (valid_q) begin
                    data_q2 <= data_q;
                end
            end
        end

        assign rvalid = valid_q2;
        assign rdata  = data_q2;
    end else begin : g_no_out_reg
        assign rvalid = valid_q;
        assign rdata  = data_q;
    end

endmodule

// File: rtl/prim_ram_2p_sync.sv
// Single-clock true dual-port RAM with grant/rvalid handshakes, masked writes,
// deterministic A-over-B collision merge and a zeroize sequencer.
module prim_ram_2p_sync
    import prim_ram_2p_pkg::*;
#(
    parameter int unsigned Width           = 32,
    parameter int unsigned Depth           = 128,
    parameter int unsigned DataBitsPerMask = 1,
    parameter int unsigned OutputReg       = 0,
    parameter rd_mode_e    RdMode          = RdModeReadFirst,
    localparam int unsigned Aw             = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             init_req_i,
    output logic             busy_o,
    output logic             collision_o,
    input  logic             a_req_i,
    output logic             a_gnt_o,
    input  logic             a_write_i,
    input  logic [Aw-1:0]    a_addr_i,
    input  logic [Width-1:0] a_wdata_i,
    input  logic [Width-1:0] a_wmask_i,
    output logic             a_rvalid_o,
    output logic [Width-1:0] a_rdata_o,
    input  logic             b_req_i,
    output logic             b_gnt_o,
    input  logic             b_write_i,
    input  logic [Aw-1:0]    b_addr_i,
    input  logic [Width-1:0] b_wdata_i,
    input  logic [Width-1:0] b_wmask_i,
    output logic             b_rvalid_o,
    output logic [Width-1:0] b_rdata_o
);

    localparam int unsigned NumGroups = Width / DataBitsPerMask;

    logic [Width-1:0] mem [Depth];
    clr_state_e       state;
    logic [Aw-1:0]    clr_ptr;

    logic             a_in_range, b_in_range;
    logic             a_we, b_we, a_rd, b_rd, same_addr;
    logic [Width-1:0] a_wbits, b_wbits;
    logic [Width-1:0] a_word, b_word;
    logic [Width-1:0] a_fwd_bits, b_fwd_bits;
    logic [Width-1:0] a_base, a_new, b_new;

    assign a_gnt_o    = a_req_i & ~busy_o;
    assign b_gnt_o    = b_req_i & ~busy_o;
    assign a_in_range = 32'(a_addr_i) < Depth;
    assign b_in_range = 32'(b_addr_i) < Depth;
    assign a_we       = a_gnt_o & a_write_i & a_in_range;
    assign b_we       = b_gnt_o & b_write_i & b_in_range;
    assign a_rd       = a_gnt_o & ~a_write_i;
    assign b_rd       = b_gnt_o & ~b_write_i;
    assign same_addr  = (a_addr_i == b_addr_i);

    // A group is written only when every bit of its mask slice is set
    for (genvar g = 0; g < NumGroups; g++) begin : g_mask
        assign a_wbits[g*DataBitsPerMask +: DataBitsPerMask] =
            {DataBitsPerMask{a_we & (&a_wmask_i[g*DataBitsPerMask +: DataBitsPerMask])}};
        assign b_wbits[g*DataBitsPerMask +: DataBitsPerMask] =
            {DataBitsPerMask{b_we & (&b_wmask_i[g*DataBitsPerMask +: DataBitsPerMask])}};
    end

    assign a_word = mem[a_addr_i];
    assign b_word = mem[b_addr_i];

    // On a same-address collision A is applied on top of B's result, so A wins per group
    assign b_new  = (b_word & ~b_wbits) | (b_wdata_i & b_wbits);
    assign a_base = (b_we && same_addr) ? b_new : a_word;
    assign a_new  = (a_base & ~a_wbits) | (a_wdata_i & a_wbits);

    assign a_fwd_bits = same_addr ? b_wbits : '0;
    assign b_fwd_bits = same_addr ? a_wbits : '0;

    always_ff @(posedge clk_i) begin
        if (state == Clear) begin
            mem[clr_ptr] <= '0;
        end else begin
            if (b_we) begin
                mem[b_addr_i] <= b_new;
            end
            if (a_we) begin
                mem[a_addr_i] <= a_new;
            end
        end
    end

    // Zeroize sequencer and collision flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= Clear;
            clr_ptr     <= '0;
            busy_o      <= 1'b1;
            collision_o <= 1'b0;
        end else begin
            collision_o <= a_we & b_we & same_addr;
            case (state)
                Clear: begin
                    if (clr_ptr == Aw'(Depth - 1)) begin
                        state   <= Idle;
                        busy_o  <= 1'b0;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + Aw'(1);
                    end
                end
                Idle: begin
                    if (init_req_i) begin
                        state   <= Clear;
                        busy_o  <= 1'b1;
                        clr_ptr <= '0;
                    end
                end
                default: begin
                    state  <= Idle;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    prim_ram_2p_rd_stage #(
        .Width     (Width),
        .OutputReg (OutputReg),
        .RdMode    (RdMode)
    ) u_rd_a (
        .clk      (clk_i),
        .rst      (rst_i),
        .rd_en    (a_rd),
        .in_range (a_in_range),
        .mem_word (a_word),
        .fwd_bits (a_fwd_bits),
        .fwd_data (b_wdata_i),
        .rvalid   (a_rvalid_o),
        .rdata    (a_rdata_o)
    );

    prim_ram_2p_rd_stage #(
        .Width     (Width),
        .OutputReg (OutputReg),
        .RdMode    (RdMode)
    ) u_rd_b (
        .clk      (clk_i),
        .rst      (rst_i),
        .rd_en    (b_rd),
        .in_range (b_in_range),
        .mem_word (b_word),
        .fwd_bits (b_fwd_bits),
        .fwd_data (a_wdata_i),
        .rvalid   (b_rvalid_o),
        .rdata    (b_rdata_o)
    );

endmodule
